// File: rtl/nf_uart_pkg.sv
// Shared types and frame constants for the nanoFOX UART periphery.
package nf_uart_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } tx_state_t;

    localparam int unsigned DATA_BITS = 8;
    localparam int unsigned STOP_BITS = 1;
    localparam logic        IDLE_LVL  = 1'b1;

endpackage

// File: rtl/nf_uart_tx_fifo.sv
// Synchronous byte FIFO for the UART transmitter; count-based full/empty, flush clears it.
module nf_uart_tx_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PtrW-1:0]  r_wr_ptr;
    logic [PtrW-1:0]  r_rd_ptr;
    logic [CntW-1:0]  r_count;
    logic             w_wr;
    logic             w_rd;

    assign o_full  = (r_count == CntW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_data  = r_mem[r_rd_ptr];

    // Fullness uses the current count, so a push while full is dropped even alongside a pop.
    assign w_wr = i_push && !o_full && !i_flush;
    assign w_rd = i_pop && !o_empty && !i_flush;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + PtrW'(1);
            if (w_rd) r_rd_ptr <= r_rd_ptr + PtrW'(1);
            if (w_wr && !w_rd)      r_count <= r_count + CntW'(1);
            else if (w_rd && !w_wr) r_count <= r_count - CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/nf_uart_transmitter.sv
// 8N1 UART transmitter with write FIFO; LSB first, bit period comp+1 clocks.
module nf_uart_transmitter
    import nf_uart_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        tr_en,
    input  logic [15:0] comp,
    input  logic [7:0]  tx_data,
    input  logic        tx_we,
    output logic        tx_full,
    output logic        tx_empty,
    output logic        tx_busy,
    output logic        tx_done,
    output logic        uart_tx
);

    if (DATA_BITS != 8 || STOP_BITS != 1 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_chk
        $error("nf_uart_transmitter: unsupported frame format or FIFO_DEPTH");
    end

    tx_state_t   r_state;
    tx_state_t   w_state_nxt;
    logic [15:0] r_cnt;
    logic [15:0] w_cnt_nxt;
    logic [15:0] r_comp_l;
    logic [15:0] w_comp_l_nxt;
    logic [2:0]  r_bit_cnt;
    logic [2:0]  w_bit_cnt_nxt;
    logic [7:0]  r_shift;
    logic [7:0]  w_shift_nxt;
    logic        r_tx;
    logic        w_tx_nxt;
    logic        w_bit_end;
    logic        w_push;
    logic        w_pop;
    logic        w_done;
    logic [7:0]  w_fifo_data;

    assign w_push    = tx_we && tr_en && !tx_full;
    assign w_bit_end = (r_cnt >= r_comp_l);

    nf_uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (!tr_en),
        .i_data  (tx_data),
        .o_data  (w_fifo_data),
        .o_full  (tx_full),
        .o_empty (tx_empty)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = (r_state == StIdle || w_bit_end) ? 16'd0 : r_cnt + 16'd1;
        w_comp_l_nxt  = r_comp_l;
        w_bit_cnt_nxt = r_bit_cnt;
        w_shift_nxt   = r_shift;
        w_tx_nxt      = IDLE_LVL;
        w_pop         = 1'b0;
        w_done        = 1'b0;
        if (!tr_en) begin
            w_state_nxt   = StIdle;
            w_cnt_nxt     = 16'd0;
            w_bit_cnt_nxt = 3'd0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (!tx_empty) begin
                        w_pop         = 1'b1;
                        w_shift_nxt   = w_fifo_data;
                        w_comp_l_nxt  = comp;
                        w_cnt_nxt     = 16'd0;
                        w_bit_cnt_nxt = 3'd0;
                        w_state_nxt   = StStart;
                    end
                end
                StStart: begin
                    w_tx_nxt = 1'b0;
                    if (w_bit_end) w_state_nxt = StData;
                end
                StData: begin
                    w_tx_nxt = r_shift[0];
                    if (w_bit_end) begin
                        w_shift_nxt   = {1'b0, r_shift[7:1]};
                        w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'(DATA_BITS - 1)) w_state_nxt = StStop;
                    end
                end
                StStop: begin
                    if (w_bit_end) begin
                        w_done = 1'b1;
                        // Chain straight into the next frame when data is waiting.
                        if (!tx_empty) begin
                            w_pop         = 1'b1;
                            w_shift_nxt   = w_fifo_data;
                            w_comp_l_nxt  = comp;
                            w_bit_cnt_nxt = 3'd0;
                            w_state_nxt   = StStart;
                        end else begin
                            w_state_nxt = StIdle;
                        end
                    end
                end
                default: w_state_nxt = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= StIdle;
            r_cnt     <= 16'd0;
            r_comp_l  <= 16'd0;
            r_bit_cnt <= 3'd0;
            r_shift   <= 8'd0;
            r_tx      <= IDLE_LVL;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_comp_l  <= w_comp_l_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_shift   <= w_shift_nxt;
            r_tx      <= w_tx_nxt;
        end
    end

    assign tx_busy = (r_state != StIdle);
    assign tx_done = w_done;
    assign uart_tx = r_tx;

endmodule
